// File: rtl/cache_pkg.sv
// Shared definitions for the cache-to-memory arbiter.
package cache_pkg;

  // Default number of 32-bit beats in a cache line refill.
  localparam int LINE_WORDS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  // Encoding matters: the round-robin picker returns 1 for the dcache.
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick: req[0] = icache, req[1] = dcache.
// grant is 0 for icache and 1 for dcache; only meaningful when req != 0.
module arb_rr2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant
);

  // A lone requester wins outright; on a tie the side not served last wins.
  always_comb begin
    grant = 1'b0;
    case (req)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache line refills and dcache reads/writes onto one memory port.
// One transaction is outstanding at a time.
//
//   state | meaning
//   IDLE  | no transaction; grant on any request
//   ADDR  | m_req high, waiting for m_addr_ok
//   DATA  | forwarding m_data_ok beats until the beat counter reaches zero
module cache_mem_arbiter
  import cache_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int AW         = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_addr_ok,
  output logic          i_data_ok,
  output logic [31:0]   i_rdata,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_addr_ok,
  output logic          d_data_ok,
  output logic [31:0]   d_rdata,
  output logic          m_req,
  output logic          m_wr,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic          m_addr_ok,
  input  logic          m_data_ok,
  input  logic [31:0]   m_rdata,
  output logic          busy
);

  // One extra bit so LINE_WORDS itself fits in the counter.
  localparam int CW = $clog2(LINE_WORDS) + 1;

  state_e        state_q;
  owner_e        owner_q;
  owner_e        last_q;
  logic [CW-1:0] cnt_q;
  logic          rr_grant;
  logic          own_d;
  logic          in_addr;
  logic          in_data;

  arb_rr2 u_rr (
    .req        ({d_req, i_req}),
    .last_grant (last_q),
    .grant      (rr_grant)
  );

  // Transaction FSM and beat counter; last_q records the winner at grant time.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      last_q  <= OWN_I;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_req || d_req) begin
            owner_q <= owner_e'(rr_grant);
            last_q  <= owner_e'(rr_grant);
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (m_addr_ok) begin
            state_q <= DATA;
            cnt_q   <= (owner_q == OWN_D && d_wr) ? CW'(1) : CW'(LINE_WORDS);
          end
        end
        DATA: begin
          if (m_data_ok) begin
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign own_d   = (owner_q == OWN_D);
  assign in_addr = (state_q == ADDR);
  assign in_data = (state_q == DATA);

  assign busy    = (state_q != IDLE);
  assign m_req   = in_addr;
  assign m_addr  = in_addr ? (own_d ? d_addr : i_addr) : '0;
  assign m_wr    = in_addr & own_d & d_wr;
  assign m_wdata = (in_addr && own_d) ? d_wdata : 32'h0;

  assign i_addr_ok = in_addr & ~own_d & m_addr_ok;
  assign d_addr_ok = in_addr &  own_d & m_addr_ok;
  assign i_data_ok = in_data & ~own_d & m_data_ok;
  assign d_data_ok = in_data &  own_d & m_data_ok;

  // Read data is broadcast; the data_ok strobes qualify it.
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter (LINE_WORDS = 8, AW = 32).
module tb_cache_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req, d_req, d_wr;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
  logic [31:0] i_rdata, d_rdata;
  logic        m_req, m_wr, m_addr_ok, m_data_ok;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        busy;

  int vecs = 0;
  int errs = 0;

  cache_mem_arbiter #(.LINE_WORDS(8), .AW(32)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
    .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1-2 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    i_req = 0; d_req = 0; d_wr = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
    tick();
    resetn = 1'b1;
    tick();
  endtask

  // One-cycle m_addr_ok pulse; reports what the arbiter showed during it.
  task automatic accept_addr(output logic ia, output logic da,
                             output logic [31:0] ma, output logic mw,
                             output logic [31:0] mwd, output logic mr);
    m_addr_ok = 1'b1;
    #1;
    ia = i_addr_ok; da = d_addr_ok; ma = m_addr; mw = m_wr; mwd = m_wdata; mr = m_req;
    tick();
    m_addr_ok = 1'b0;
  endtask

  // n consecutive m_data_ok beats; counts strobes and rdata broadcast errors.
  task automatic serve(input int n, output int ic, output int dc, output int rd_bad);
    ic = 0; dc = 0; rd_bad = 0;
    for (int k = 0; k < n; k++) begin
      m_data_ok = 1'b1;
      m_rdata   = 32'hC0DE_0000 + k;
      #1;
      if (i_data_ok) ic++;
      if (d_data_ok) dc++;
      if (i_rdata !== 32'hC0DE_0000 + k || d_rdata !== 32'hC0DE_0000 + k) rd_bad++;
      tick();
    end
    m_data_ok = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    i_req = 0; d_req = 0; d_wr = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0;
    m_addr_ok = 1; m_data_ok = 1; m_rdata = 0;
    #2;
    vecs++;
    if ({m_req, busy, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok} !== 6'b0) begin
      errs++;
      $display("FAIL reset_outputs: got %b want 000000",
               {m_req, busy, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok});
    end
    do_reset();
  endtask

  task automatic test_icache_read();
    logic ia, da, mw, mr;
    logic [31:0] ma, mwd;
    int ic, dc, rb;
    i_req = 1; i_addr = 32'h1FC0_0000;
    #1;
    vecs++;
    if (m_req !== 1'b0) begin errs++; $display("FAIL icache_latency_same_cycle: m_req=%b want 0", m_req); end
    tick();
    vecs++;
    if (m_req !== 1'b1 || busy !== 1'b1) begin
      errs++; $display("FAIL icache_grant: m_req=%b busy=%b want 1 1", m_req, busy);
    end
    vecs++;
    if (m_addr !== 32'h1FC0_0000 || m_wr !== 1'b0 || m_wdata !== 32'h0) begin
      errs++; $display("FAIL icache_mport: addr=%h wr=%b wdata=%h want 1fc00000 0 00000000", m_addr, m_wr, m_wdata);
    end
    tick();
    accept_addr(ia, da, ma, mw, mwd, mr);
    i_req = 0;
    vecs++;
    if (ia !== 1'b1 || da !== 1'b0 || mr !== 1'b1) begin
      errs++; $display("FAIL icache_addr_ok: i=%b d=%b m_req=%b want 1 0 1", ia, da, mr);
    end
    vecs++;
    if (m_req !== 1'b0 || busy !== 1'b1) begin
      errs++; $display("FAIL icache_data_state: m_req=%b busy=%b want 0 1", m_req, busy);
    end
    serve(8, ic, dc, rb);
    vecs++;
    if (ic !== 8 || dc !== 0) begin errs++; $display("FAIL icache_beats: i=%0d d=%0d want 8 0", ic, dc); end
    vecs++;
    if (rb !== 0) begin errs++; $display("FAIL icache_rdata: %0d bad beats want 0", rb); end
    vecs++;
    if (busy !== 1'b0) begin errs++; $display("FAIL icache_done_busy: busy=%b want 0", busy); end
  endtask

  task automatic test_tie();
    logic ia, da, mw, mr;
    logic [31:0] ma, mwd;
    int ic, dc, rb;
    do_reset();
    i_req = 1; i_addr = 32'h0000_1000;
    d_req = 1; d_addr = 32'h0000_2000; d_wr = 0;
    tick();
    vecs++;
    if (m_req !== 1'b1 || m_addr !== 32'h0000_2000) begin
      errs++; $display("FAIL tie1_grant_d: m_req=%b addr=%h want 1 00002000", m_req, m_addr);
    end
    accept_addr(ia, da, ma, mw, mwd, mr);
    vecs++;
    if (ia !== 1'b0 || da !== 1'b1) begin errs++; $display("FAIL tie1_addr_ok: i=%b d=%b want 0 1", ia, da); end
    serve(8, ic, dc, rb);
    vecs++;
    if (ic !== 0 || dc !== 8) begin errs++; $display("FAIL tie1_beats: i=%0d d=%0d want 0 8", ic, dc); end
    vecs++;
    if (busy !== 1'b0 || m_req !== 1'b0) begin
      errs++; $display("FAIL tie_dead_cycle: busy=%b m_req=%b want 0 0", busy, m_req);
    end
    tick();
    vecs++;
    if (m_req !== 1'b1 || m_addr !== 32'h0000_1000) begin
      errs++; $display("FAIL tie2_grant_i: m_req=%b addr=%h want 1 00001000", m_req, m_addr);
    end
    accept_addr(ia, da, ma, mw, mwd, mr);
    vecs++;
    if (ia !== 1'b1 || da !== 1'b0) begin errs++; $display("FAIL tie2_addr_ok: i=%b d=%b want 1 0", ia, da); end
    serve(8, ic, dc, rb);
    vecs++;
    if (ic !== 8 || dc !== 0) begin errs++; $display("FAIL tie2_beats: i=%0d d=%0d want 8 0", ic, dc); end
    tick();
    vecs++;
    if (m_addr !== 32'h0000_2000) begin errs++; $display("FAIL tie3_grant_d: addr=%h want 00002000", m_addr); end
    i_req = 0;
    accept_addr(ia, da, ma, mw, mwd, mr);
    d_req = 0;
    serve(8, ic, dc, rb);
    vecs++;
    if (ic !== 0 || dc !== 8 || busy !== 1'b0) begin
      errs++; $display("FAIL tie3_beats: i=%0d d=%0d busy=%b want 0 8 0", ic, dc, busy);
    end
  endtask

  task automatic test_write();
    logic ia, da, mw, mr;
    logic [31:0] ma, mwd;
    int ic, dc, rb;
    d_req = 1; d_wr = 1; d_addr = 32'h8000_0010; d_wdata = 32'hDEAD_BEEF;
    tick();
    accept_addr(ia, da, ma, mw, mwd, mr);
    d_req = 0; d_wr = 0;
    vecs++;
    if (ma !== 32'h8000_0010 || mw !== 1'b1 || mwd !== 32'hDEAD_BEEF) begin
      errs++; $display("FAIL write_mport: addr=%h wr=%b wdata=%h want 80000010 1 deadbeef", ma, mw, mwd);
    end
    vecs++;
    if (da !== 1'b1 || ia !== 1'b0) begin errs++; $display("FAIL write_addr_ok: i=%b d=%b want 0 1", ia, da); end
    serve(1, ic, dc, rb);
    vecs++;
    if (dc !== 1 || ic !== 0 || busy !== 1'b0) begin
      errs++; $display("FAIL write_done: d=%0d i=%0d busy=%b want 1 0 0", dc, ic, busy);
    end
  endtask

  task automatic test_spurious();
    logic ia, da, mw, mr;
    logic [31:0] ma, mwd;
    int ic, dc, rb;
    serve(2, ic, dc, rb);
    m_addr_ok = 1;
    tick();
    m_addr_ok = 0;
    vecs++;
    if (ic !== 0 || dc !== 0 || busy !== 1'b0) begin
      errs++; $display("FAIL spurious_idle: i=%0d d=%0d busy=%b want 0 0 0", ic, dc, busy);
    end
    i_req = 1; i_addr = 32'h0000_4440;
    tick();
    serve(2, ic, dc, rb);
    vecs++;
    if (ic !== 0 || dc !== 0 || m_req !== 1'b1) begin
      errs++; $display("FAIL spurious_addr: i=%0d d=%0d m_req=%b want 0 0 1", ic, dc, m_req);
    end
    accept_addr(ia, da, ma, mw, mwd, mr);
    i_req = 0;
    serve(7, ic, dc, rb);
    vecs++;
    if (ic !== 7 || busy !== 1'b1) begin
      errs++; $display("FAIL spurious_count_7: i=%0d busy=%b want 7 1", ic, busy);
    end
    serve(1, ic, dc, rb);
    vecs++;
    if (ic !== 1 || busy !== 1'b0) begin
      errs++; $display("FAIL spurious_count_8: i=%0d busy=%b want 1 0", ic, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic ia, da, mw, mr;
    logic [31:0] ma, mwd;
    int ic, dc, rb;
    i_req = 1; i_addr = 32'h0000_5500;
    tick();
    accept_addr(ia, da, ma, mw, mwd, mr);
    i_req = 0;
    serve(3, ic, dc, rb);
    resetn = 1'b0;
    #1;
    vecs++;
    if (m_req !== 1'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL reset_mid_async: m_req=%b busy=%b want 0 0", m_req, busy);
    end
    tick();
    resetn = 1'b1;
    tick();
    serve(5, ic, dc, rb);
    vecs++;
    if (ic !== 0 || dc !== 0 || busy !== 1'b0) begin
      errs++; $display("FAIL reset_mid_leftover: i=%0d d=%0d busy=%b want 0 0 0", ic, dc, busy);
    end
    i_req = 1; i_addr = 32'h0000_6600;
    tick();
    vecs++;
    if (m_req !== 1'b1 || m_addr !== 32'h0000_6600) begin
      errs++; $display("FAIL reset_mid_regrant: m_req=%b addr=%h want 1 00006600", m_req, m_addr);
    end
    accept_addr(ia, da, ma, mw, mwd, mr);
    i_req = 0;
    serve(8, ic, dc, rb);
    vecs++;
    if (ic !== 8 || busy !== 1'b0) begin
      errs++; $display("FAIL reset_mid_refill: i=%0d busy=%b want 8 0", ic, busy);
    end
  endtask

  initial begin
    test_reset();
    test_icache_read();
    test_tie();
    test_write();
    test_spurious();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
